// File: rtl/conv_pkg.sv
// Shared encodings for the convolution front end: scan directions and
// the scan controller state enum (also used by the window-memory stage).
package conv_pkg;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'b00,
    DIR_LEFT  = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_DOWN2 = 2'b11
  } dir_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_GUARD,
    ST_WAIT,
    ST_REQ,
    ST_DONE
  } state_t;

endpackage

// File: rtl/serpentine_scan.sv
// Serpentine window scanner: walks the top-left corner of a KxK window
// across a WxH image, right along even rows and left along odd rows,
// handshaking one window at a time with the window-memory stage.
module serpentine_scan
  import conv_pkg::*;
#(
  parameter int X_MAX      = 60,
  parameter int Y_MAX      = 60,
  parameter int MAX_KERNAL = 31
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic [$clog2(X_MAX+1)-1:0]   img_width,
  input  logic [$clog2(Y_MAX+1)-1:0]   img_height,
  input  logic [7:0]                   kernel_size,
  input  logic                         new_sample_ready,
  output logic [$clog2(X_MAX)-1:0]     curr_x,
  output logic [$clog2(Y_MAX)-1:0]     curr_y,
  output logic [1:0]                   next_dir,
  output logic                         new_sample_req,
  output logic                         new_trans,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  localparam int WW  = $clog2(X_MAX+1);
  localparam int HW  = $clog2(Y_MAX+1);
  localparam int XW  = $clog2(X_MAX);
  localparam int YW  = $clog2(Y_MAX);
  localparam int MW  = (WW > HW) ? WW : HW;
  localparam int CW  = ((MW > 8) ? MW : 8) + 1;

  state_t          state, state_nx;
  dir_t            dir, dir_nx;
  logic [XW-1:0]   x, x_nx, x_lim;
  logic [YW-1:0]   y, y_nx, y_lim;
  logic            row_right, row_nx;
  logic            err_q;

  // Configuration check, done in a width wide enough for every operand.
  logic [CW-1:0] w_ext, h_ext, k_ext;
  logic          cfg_ok;
  assign w_ext  = CW'(img_width);
  assign h_ext  = CW'(img_height);
  assign k_ext  = CW'(kernel_size);
  assign cfg_ok = (k_ext != '0) && (k_ext <= CW'(MAX_KERNAL)) &&
                  (k_ext <= w_ext) && (k_ext <= h_ext);

  // Scan ends at the bottom row, at the far edge in the row's direction.
  logic last_pos;
  assign last_pos = (y == y_lim) && (row_right ? (x == x_lim) : (x == '0));

  // Next position after applying dir, and the direction to take from there.
  always_comb begin
    x_nx   = x;
    y_nx   = y;
    row_nx = row_right;
    unique case (dir)
      DIR_RIGHT: x_nx = x + XW'(1);
      DIR_LEFT:  x_nx = x - XW'(1);
      default: begin
        y_nx   = y + YW'(1);
        row_nx = ~row_right;
      end
    endcase
    if (x_lim == '0)  dir_nx = DIR_DOWN;
    else if (row_nx)  dir_nx = (x_nx < x_lim) ? DIR_RIGHT : DIR_DOWN;
    else              dir_nx = (x_nx != '0)   ? DIR_LEFT  : DIR_DOWN2;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // FSM next state and handshake outputs; abort overrides everything.
  always_comb begin
    state_nx       = state;
    new_sample_req = 1'b0;
    new_trans      = 1'b0;
    done           = 1'b0;
    if (state != ST_IDLE && abort) begin
      state_nx  = ST_IDLE;
      new_trans = 1'b1;
    end else begin
      unique case (state)
        ST_IDLE:  if (start && cfg_ok) state_nx = ST_INIT;
        ST_INIT: begin
          new_trans = 1'b1;
          state_nx  = ST_GUARD;
        end
        ST_GUARD: state_nx = ST_WAIT;
        ST_WAIT:  if (new_sample_ready) state_nx = ST_REQ;
        ST_REQ: begin
          new_sample_req = 1'b1;
          state_nx       = last_pos ? ST_DONE : ST_GUARD;
        end
        ST_DONE: begin
          done     = 1'b1;
          state_nx = ST_IDLE;
        end
        default:  state_nx = ST_IDLE;
      endcase
    end
  end

  // Position, direction and latched limits; only the limits W-K and H-K
  // are kept, since nothing downstream of the check needs W, H or K.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x         <= '0;
      y         <= '0;
      x_lim     <= '0;
      y_lim     <= '0;
      row_right <= 1'b1;
      dir       <= DIR_RIGHT;
      err_q     <= 1'b0;
    end else begin
      err_q <= (state == ST_IDLE) && start && !cfg_ok;
      if (state == ST_IDLE && start && cfg_ok) begin
        x_lim <= XW'(w_ext - k_ext);
        y_lim <= YW'(h_ext - k_ext);
      end
      if (state == ST_INIT && !abort) begin
        x         <= '0;
        y         <= '0;
        row_right <= 1'b1;
        dir       <= (x_lim != '0) ? DIR_RIGHT : DIR_DOWN;
      end
      if (state == ST_REQ && !abort && !last_pos) begin
        x         <= x_nx;
        y         <= y_nx;
        row_right <= row_nx;
        dir       <= dir_nx;
      end
    end
  end

  assign curr_x   = x;
  assign curr_y   = y;
  assign next_dir = dir;
  assign busy     = (state != ST_IDLE);
  assign err      = err_q;

endmodule

// File: tb/tb_serpentine_scan.sv
// Bench for serpentine_scan: table of configurations (valid scans and
// rejected kernels), random scans with random ready, and hand-written
// stall / abort / reset-mid-scan sequences.
module tb_serpentine_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [5:0] img_width = '0;
  logic [5:0] img_height = '0;
  logic [7:0] kernel_size = '0;
  logic       new_sample_ready = 1'b0;
  logic [5:0] curr_x;
  logic [5:0] curr_y;
  logic [1:0] next_dir;
  logic       new_sample_req, new_trans, busy, done, err;

  int checks = 0;
  int errors = 0;

  serpentine_scan #(.X_MAX(60), .Y_MAX(60), .MAX_KERNAL(31)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .img_width(img_width), .img_height(img_height), .kernel_size(kernel_size),
    .new_sample_ready(new_sample_ready),
    .curr_x(curr_x), .curr_y(curr_y), .next_dir(next_dir),
    .new_sample_req(new_sample_req), .new_trans(new_trans),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference walk: row r of 0..H-K runs x upward on even rows, downward
  // on odd rows; the direction shown at a window is the move to the next
  // one (or what the row edge implies at the final window).
  task automatic run_scan(input int w, input int h, input int k, input bit rnd);
    int ex[$], ey[$], ed[$];
    int xl, yl, idx, cyc, dones, trans;
    bit fin;
    xl = w - k;
    yl = h - k;
    for (int r = 0; r <= yl; r++)
      for (int i = 0; i <= xl; i++) begin
        ex.push_back((r % 2 == 0) ? i : xl - i);
        ey.push_back(r);
        if (xl == 0)     ed.push_back(2);
        else if (i < xl) ed.push_back((r % 2 == 0) ? 0 : 1);
        else             ed.push_back((r % 2 == 0) ? 2 : 3);
      end
    @(negedge clk);
    img_width = 6'(w); img_height = 6'(h); kernel_size = 8'(k);
    new_sample_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("init_trans", new_trans, 1);
    check("init_busy", busy, 1);
    idx = 0; cyc = 0; dones = 0; trans = 0; fin = 0;
    while (!fin && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (new_trans) trans++;
      if (new_sample_req) begin
        if (idx < ex.size()) begin
          check("req_x", curr_x, ex[idx]);
          check("req_y", curr_y, ey[idx]);
          check("req_dir", next_dir, ed[idx]);
        end
        idx++;
      end
      if (done) begin dones++; fin = 1; end
      new_sample_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    check("scan_done_seen", dones, 1);
    check("req_count", idx, (xl + 1) * (yl + 1));
    check("no_mid_trans", trans, 0);
    @(negedge clk);
    check("idle_after_done", busy, 0);
    check("done_single", done, 0);
  endtask

  task automatic check_err(input int w, input int h, input int k);
    @(negedge clk);
    img_width = 6'(w); img_height = 6'(h); kernel_size = 8'(k);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("err_pulse", err, 1);
    check("err_busy", busy, 0);
    check("err_trans", new_trans, 0);
    @(negedge clk);
    check("err_clear", err, 0);
    check("err_busy2", busy, 0);
    check("err_trans2", new_trans, 0);
  endtask

  typedef struct {
    int w; int h; int k; bit exp_err; bit rnd;
  } vec_t;

  initial begin
    vec_t vecs[$];
    int reqs, moved;
    vecs.push_back('{5, 5, 3, 1'b0, 1'b0});
    vecs.push_back('{3, 5, 3, 1'b0, 1'b0});
    vecs.push_back('{5, 5, 0, 1'b1, 1'b0});
    vecs.push_back('{40, 40, 32, 1'b1, 1'b0});
    vecs.push_back('{5, 8, 6, 1'b1, 1'b0});
    vecs.push_back('{1, 1, 1, 1'b0, 1'b0});
    vecs.push_back('{6, 6, 6, 1'b0, 1'b1});
    vecs.push_back('{7, 4, 2, 1'b0, 1'b1});
    vecs.push_back('{4, 7, 1, 1'b0, 1'b1});
    vecs.push_back('{60, 60, 60, 1'b1, 1'b0});
    vecs.push_back('{60, 40, 31, 1'b0, 1'b0});

    // Reset values
    @(negedge clk);
    check("rst_x", curr_x, 0);
    check("rst_y", curr_y, 0);
    check("rst_dir", next_dir, 0);
    check("rst_busy", busy, 0);
    check("rst_outs", {new_sample_req, new_trans, done, err}, 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      if (vecs[i].exp_err) check_err(vecs[i].w, vecs[i].h, vecs[i].k);
      else run_scan(vecs[i].w, vecs[i].h, vecs[i].k, vecs[i].rnd);
    end

    // Random valid scans with random ready
    for (int n = 0; n < 8; n++) begin
      int w, h, k, m;
      w = $urandom_range(1, 12);
      h = $urandom_range(1, 12);
      m = (w < h) ? w : h;
      k = $urandom_range(1, m);
      run_scan(w, h, k, 1'b1);
    end

    // Stall in WAIT: 20 cycles with ready low, then one cycle to req
    @(negedge clk);
    img_width = 6'd5; img_height = 6'd5; kernel_size = 8'd3;
    new_sample_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reqs = 0; moved = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (new_sample_req) reqs++;
      if (curr_x != 0 || curr_y != 0 || next_dir != 0 || !busy) moved++;
    end
    check("stall_no_req", reqs, 0);
    check("stall_stable", moved, 0);
    new_sample_ready = 1'b1;
    @(negedge clk);
    new_sample_ready = 1'b0;
    check("stall_req_next", new_sample_req, 1);
    @(negedge clk);
    check("stall_req_once", new_sample_req, 0);
    check("stall_moved_x", curr_x, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;

    // Abort at the fourth WAIT
    @(negedge clk);
    new_sample_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reqs = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (new_sample_req) reqs++;
    end
    @(negedge clk);
    abort = 1'b1;
    #1;
    check("abort_reqs_before", reqs, 3);
    check("abort_trans", new_trans, 1);
    check("abort_no_req", new_sample_req, 0);
    check("abort_no_done", done, 0);
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle", busy, 0);
    check("abort_trans_clear", new_trans, 0);
    check("abort_done_clear", done, 0);
    run_scan(5, 5, 3, 1'b0);

    // Reset during REQ
    @(negedge clk);
    new_sample_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("rq_in_req", new_sample_req, 1);
    check("rq_pos_x", curr_x, 1);
    #1 rst = 1'b1;
    #1;
    check("rq_req_drop", new_sample_req, 0);
    check("rq_x", curr_x, 0);
    check("rq_y", curr_y, 0);
    check("rq_dir", next_dir, 0);
    check("rq_busy", busy, 0);
    check("rq_outs", {new_trans, done, err}, 0);
    @(negedge clk);
    rst = 1'b0;
    moved = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (busy || new_sample_req || new_trans) moved++;
    end
    check("rq_needs_start", moved, 0);
    run_scan(5, 5, 3, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
